// File: rtl/rom_fetch_pkg.sv
// Shared widths and FSM encoding for the ROM fetch sequencer.
package rom_fetch_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;
endpackage

// File: rtl/rom_fetch_unit.sv
// Walks a burst of consecutive ROM addresses and streams each word out over
// a valid/ready handshake, flagging the last word and pulsing done on its accept.
module rom_fetch_unit
    import rom_fetch_pkg::*;
#(
    parameter int ADDR_W = rom_fetch_pkg::ADDR_W,
    parameter int DATA_W = rom_fetch_pkg::DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic [ADDR_W-1:0] Length,
    output logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] RomData,
    output logic [DATA_W-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              OutLast,
    output logic              Busy,
    output logic              Done
);
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                capture;
    logic                accept;

    // A new word may be captured whenever the output slot is empty or draining this cycle.
    assign capture = (state_q == FETCH) && (!valid_q || OutReady);
    assign accept  = valid_q && OutReady;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (Length != '0) begin
                        addr_d  = StartAddr;
                        rem_d   = Length;
                        state_d = FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (capture) begin
                    data_d  = RomData;
                    valid_d = 1'b1;
                    last_d  = (rem_q == ADDR_W'(1));
                    addr_d  = addr_q + ADDR_W'(1);
                    rem_d   = rem_q - ADDR_W'(1);
                    if (rem_q == ADDR_W'(1)) state_d = DRAIN;
                end else if (accept) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            DRAIN: begin
                if (accept) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Address  = addr_q;
    assign OutData  = data_q;
    assign OutValid = valid_q;
    assign OutLast  = last_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed + randomized bench: a behavioural ROM and an expected-word queue per burst.
module tb_rom_fetch_unit;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] StartAddr = '0;
    logic [7:0] Length = '0;
    logic [7:0] Address;
    logic [7:0] RomData;
    logic [7:0] OutData;
    logic       OutValid;
    logic       OutReady = 1'b0;
    logic       OutLast;
    logic       Busy;
    logic       Done;

    logic [7:0] rom [256];
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    assign RomData = rom[Address];

    rom_fetch_unit dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Length(Length), .Address(Address), .RomData(RomData),
        .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
        .OutLast(OutLast), .Busy(Busy), .Done(Done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high, 1: random ready, 2: ready from pat (bit 0 first)
    task automatic run_burst(input logic [7:0] sa, input logic [7:0] len, input int mode,
                             input logic [15:0] pat, input bit lat_chk, input bit inject);
        logic [7:0] exp_q [$];
        int got, cyc;
        logic pv, pr, pl;
        logic [7:0] pd, pa;
        for (int i = 0; i < int'(len); i++) exp_q.push_back(rom[8'((int'(sa) + i) % 256)]);
        @(negedge Clk);
        Start = 1'b1; StartAddr = sa; Length = len; OutReady = 1'b0;
        got = 0; cyc = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pa = '0;
        while (got < int'(len) && cyc < 400) begin
            @(negedge Clk);
            cyc++;
            Start = 1'b0;
            if (inject && cyc == 2) begin
                Start = 1'b1; StartAddr = 8'd9; Length = 8'd3;
            end
            if (cyc == 1) begin
                chk("start_addr", 32'(Address), 32'(sa));
                chk("busy_fetch", 32'(Busy), 32'd1);
            end
            if (lat_chk && cyc == 1) chk("lat_not_yet_valid", 32'(OutValid), 32'd0);
            if (lat_chk && cyc == 2) chk("lat_valid", 32'(OutValid), 32'd1);
            chk("done_low_in_burst", 32'(Done), 32'd0);
            if (pv && !pr) begin
                chk("hold_valid", 32'(OutValid), 32'd1);
                chk("hold_data", 32'(OutData), 32'(pd));
                chk("hold_last", 32'(OutLast), 32'(pl));
                chk("hold_addr", 32'(Address), 32'(pa));
            end
            case (mode)
                0:       OutReady = 1'b1;
                1:       OutReady = 1'($urandom_range(0, 1));
                default: OutReady = (cyc <= 16) ? pat[cyc-1] : 1'b1;
            endcase
            if (OutValid && OutReady) begin
                chk("data", 32'(OutData), 32'(exp_q[got]));
                chk("last", 32'(OutLast), 32'(got == int'(len) - 1));
                got++;
            end
            pv = OutValid; pr = OutReady; pd = OutData; pl = OutLast; pa = Address;
        end
        chk("burst_count", 32'(got), 32'(len));
        @(negedge Clk);
        Start = 1'b0; OutReady = 1'b0;
        chk("done_pulse", 32'(Done), 32'd1);
        chk("busy_after", 32'(Busy), 32'd0);
        chk("valid_after", 32'(OutValid), 32'd0);
        chk("end_addr", 32'(Address), 32'((int'(sa) + int'(len)) % 256));
        @(negedge Clk);
        chk("done_once", 32'(Done), 32'd0);
    endtask

    initial begin
        int waitc;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);

        // reset state
        repeat (2) @(negedge Clk);
        chk("rst_addr", 32'(Address), 32'd0);
        chk("rst_data", 32'(OutData), 32'd0);
        chk("rst_valid", 32'(OutValid), 32'd0);
        chk("rst_last", 32'(OutLast), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        Reset = 1'b0;

        // full-rate burst with latency check
        run_burst(8'd0, 8'd6, 0, 16'h0, 1'b1, 1'b0);
        // back-pressure pattern 1,0,0,1,0,1
        run_burst(8'd2, 8'd3, 2, 16'hFFE9, 1'b0, 1'b0);
        // address wrap
        run_burst(8'd254, 8'd4, 0, 16'h0, 1'b0, 1'b0);

        // zero-length request
        @(negedge Clk);
        Start = 1'b1; StartAddr = 8'd40; Length = 8'd0;
        @(negedge Clk);
        Start = 1'b0;
        chk("zero_done", 32'(Done), 32'd1);
        chk("zero_busy", 32'(Busy), 32'd0);
        chk("zero_valid", 32'(OutValid), 32'd0);
        @(negedge Clk);
        chk("zero_done_once", 32'(Done), 32'd0);
        chk("zero_valid2", 32'(OutValid), 32'd0);

        // Start during FETCH is ignored
        run_burst(8'd20, 8'd6, 0, 16'h0, 1'b0, 1'b1);

        // randomized bursts with random back-pressure
        for (int b = 0; b < 8; b++)
            run_burst(8'($urandom), 8'($urandom_range(1, 20)), 1, 16'h0, 1'b0, 1'b0);

        // reset while a word is pending
        @(negedge Clk);
        Start = 1'b1; StartAddr = 8'd100; Length = 8'd5; OutReady = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        waitc = 0;
        while (!OutValid && waitc < 20) begin
            @(negedge Clk);
            waitc++;
        end
        chk("mid_valid_seen", 32'(OutValid), 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        chk("mid_rst_addr", 32'(Address), 32'd0);
        chk("mid_rst_data", 32'(OutData), 32'd0);
        chk("mid_rst_valid", 32'(OutValid), 32'd0);
        chk("mid_rst_last", 32'(OutLast), 32'd0);
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_done", 32'(Done), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("post_rst_done", 32'(Done), 32'd0);
        chk("post_rst_busy", 32'(Busy), 32'd0);
        run_burst(8'd1, 8'd1, 0, 16'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rom_fetch_unit.md
Name: rom_fetch_unit

Overview:
- Address sequencer that sits directly upstream of the combinational 8-bit ROM. It drives the ROM Address port and consumes the ROM Out word.
- On Start it walks Length consecutive addresses from StartAddr and registers each ROM word into an output register.
- Words are presented downstream with a valid/ready handshake; the last word is flagged, and Done pulses when the last word is accepted.

Parameters:
ADDR_W, 8, ROM address width
DATA_W, 8, ROM data width

Ports:
Clk  input  1  single clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request a burst; sampled only in IDLE
StartAddr  input  ADDR_W  first ROM address of the burst
Length  input  ADDR_W  number of words to fetch (0..255)
Address  output  ADDR_W  registered address to ROM
RomData  input  DATA_W  combinational ROM output for Address
OutData  output  DATA_W  registered fetched word
OutValid  output  1  OutData holds a word not yet accepted
OutReady  input  1  downstream accepts OutData this cycle
OutLast  output  1  qualifies OutData as the final word of the burst
Busy  output  1  high in FETCH and DRAIN
Done  output  1  one-cycle pulse at end of burst

Behaviour:
- Reset (Reset high at a Clk edge): state=IDLE; Address=0, OutData=0, OutValid=0, OutLast=0, Busy=0, Done=0, remaining=0.
- Reset asserted mid-burst aborts immediately. A pending OutValid word is dropped, and no Done is issued.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE, Start=1, Length!=0: Address<=StartAddr, remaining<=Length, go to FETCH.
- IDLE, Start=1, Length==0: no fetch. Done=1 next cycle, stay in IDLE.
- Start outside IDLE is ignored.
- capture = (state==FETCH) && (!OutValid || OutReady).
- On capture:
  - OutData<=RomData; OutValid<=1; OutLast<=(remaining==1).
  - Address<=Address+1, mod 2^ADDR_W (255 wraps to 0).
  - remaining<=remaining-1.
  - If remaining==1, go to DRAIN.
- Without capture, OutValid&&OutReady clears OutValid (and OutLast).
- OutData, OutValid and OutLast are stable while OutValid=1 and OutReady=0.
- Address does not advance without a capture. RomData therefore stays stable because the ROM is combinational.
- DRAIN: on OutValid&&OutReady (the OutLast word), clear OutValid and OutLast, set Done=1 for exactly one cycle, go to IDLE.
  - A new Start is accepted in the cycle after Done.
- Latency: Start at edge N → Address=StartAddr after N → OutValid=1 with ROM[StartAddr] after N+1.
- Throughput: 1 word/cycle while OutReady=1.
- Burst length Length gives exactly Length accepted words. OutLast is high on exactly one of them.
- In FETCH, an Address value that crosses 255→0 is legal and not an error.
- Busy = (state!=IDLE), registered with the state.
- Done is never high while Busy=1.

Decomposition:
- Package rom_fetch_pkg holds:
  - localparam ADDR_W=8, DATA_W=8;
  - state typedef {IDLE, FETCH, DRAIN}, 2-bit encoding.
- The block is a single module; no sub-module is natural.
- The bench instantiates the existing ROM with Address→Address and Out→RomData.

Test Plan:
1. Reset, then StartAddr=0, Length=6, OutReady=1 held → OutData = ROM[0..5] on 6 consecutive cycles starting 2 cycles after Start. OutLast only on ROM[5]. Done pulses 1 cycle after the last accept; Busy then low.
2. StartAddr=2, Length=3, OutReady toggled 1,0,0,1,0,1 → each word is held stable while OutReady=0. Order is ROM[2], ROM[3], ROM[4], with no duplicates or skips. Address never advances while stalled.
3. StartAddr=254, Length=4 → words are ROM[254], ROM[255], ROM[0], ROM[1]; Address wraps to 0.
4. Length=0 with Start → no OutValid. Done=1 one cycle later; Busy stays 0.
5. Start pulsed again during FETCH with StartAddr=9 → ignored; the original burst completes unchanged.
6. Reset asserted while OutValid=1 mid-burst → next cycle all outputs are 0 and state is IDLE, with no Done. A following Start with StartAddr=1, Length=1 returns ROM[1] with OutLast=1.
